// File: rtl/sysarr_output_collector.sv
// ---------------------------------------------------------------------------
// sysarr_output_collector
//   Collects result rows from the systolic array into two ping-pong banks of
//   N rows each. Rows may arrive in any order. A bank whose row mask is
//   complete is streamed to writeback one row per valid/ready handshake, in
//   row order 0..N-1, tagged with a wrapping tile sequence number.
//   collector_full tells the array control path to hold out_en.
//
//   Optional feature macro: SYSARR_COLLECT_FLUSH_EN
//     When defined, a partially filled bank is promoted to FULL once the array
//     reports `drained` for two consecutive cycles. Rows that were never
//     written drain as zero. When undefined, `drained` is ignored.
// ---------------------------------------------------------------------------
module sysarr_output_collector #(
    parameter int N      = 4,
    parameter int WIDTH  = 16,
    parameter int TILE_W = 8
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  out_en,
    input  logic [$clog2(N)-1:0]  row_out,
    input  logic [N*WIDTH-1:0]    array_output,
    input  logic                  drained,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [N*WIDTH-1:0]    wb_data,
    output logic [$clog2(N)-1:0]  wb_row,
    output logic [TILE_W-1:0]     wb_tile,
    output logic                  wb_last,
    output logic                  collector_full,
    output logic                  overflow_err
);

    localparam int RW = $clog2(N);
    localparam int DW = N * WIDTH;

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_SEND = 1'b1
    } drain_state_t;

    // Bank bookkeeping (registered) and its next-state values.
    bank_state_t       bank_state   [2];
    bank_state_t       bank_state_n [2];
    logic [N-1:0]      mask         [2];
    logic [N-1:0]      mask_n       [2];
    logic [DW-1:0]     bank_data    [2][N];

    logic              fill_ptr;
    logic              fill_ptr_n;
    logic              drain_ptr;
    logic              other_ptr;
    drain_state_t      d_state;
    drain_state_t      d_state_n;
    logic [RW-1:0]     rcnt;
    logic              collector_full_n;

    // Per-cycle decode.
    logic              hs;
    logic              last_hs;
    logic [1:0]        freeing;
    logic              fill_writable;
    logic              wr_en;
    logic [N-1:0]      row_bit;
    logic [N-1:0]      fill_mask_new;
    logic              fill_complete;
    logic              flush_fire;
    logic              promote;
    logic [1:0]        becomes_full;
    logic              start;
    logic              start_bank;
    logic [DW-1:0]     rd_row;

    assign other_ptr = ~drain_ptr;
    assign row_bit   = {{(N-1){1'b0}}, 1'b1} << row_out;

    // The drain FSM is registered, so wb_valid comes straight from a flop.
    assign wb_valid = (d_state == D_SEND);
    assign hs       = wb_valid && wb_ready;
    assign last_hs  = hs && (rcnt == RW'(N - 1));
    assign freeing  = {last_hs && drain_ptr, last_hs && !drain_ptr};

    // A bank accepts rows while EMPTY/FILLING, or in the very cycle its drain
    // completes (it then restarts as FILLING holding only the new row).
    assign fill_writable = (bank_state[fill_ptr] == B_EMPTY)   ||
                           (bank_state[fill_ptr] == B_FILLING) ||
                           freeing[fill_ptr];
    assign wr_en         = out_en && !collector_full && fill_writable;

    assign fill_mask_new = (freeing[fill_ptr] ? {N{1'b0}} : mask[fill_ptr]) |
                           (wr_en ? row_bit : {N{1'b0}});
    assign fill_complete = wr_en && (&fill_mask_new);

`ifdef SYSARR_COLLECT_FLUSH_EN
    logic drained_q;

    // Promote a partial bank once the array has been idle for two cycles.
    assign flush_fire = drained && drained_q && !fill_complete &&
                        (bank_state[fill_ptr] == B_FILLING) && !freeing[fill_ptr];
`else
    logic unused_drained;

    assign unused_drained = drained;
    assign flush_fire     = 1'b0;
`endif

    assign promote      = fill_complete || flush_fire;
    assign becomes_full = {promote && fill_ptr, promote && !fill_ptr};
    assign fill_ptr_n   = promote ? ~fill_ptr : fill_ptr;

    // Drain FSM next state: start on a bank that is FULL now or becomes FULL
    // this cycle, and chain straight into the other bank after the last beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        d_state_n  = d_state;
        start      = 1'b0;
        start_bank = drain_ptr;
        case (d_state)
            D_IDLE: begin
                if ((bank_state[drain_ptr] == B_FULL) || becomes_full[drain_ptr]) begin
                    d_state_n  = D_SEND;
                    start      = 1'b1;
                    start_bank = drain_ptr;
                end
            end
            D_SEND: begin
                if (last_hs) begin
                    if ((bank_state[other_ptr] == B_FULL) || becomes_full[other_ptr]) begin
                        d_state_n  = D_SEND;
                        start      = 1'b1;
                        start_bank = other_ptr;
                    end else begin
                        d_state_n  = D_IDLE;
                    end
                end
            end
            default: d_state_n = D_IDLE;
        endcase
    end

    // Bank state/mask next values: free, then fill, then promote, then claim.
    always_comb begin
        collector_full_n = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bank_state_n[b] = bank_state[b];
            mask_n[b]       = mask[b];
            if (freeing[b]) begin
                bank_state_n[b] = B_EMPTY;
                mask_n[b]       = {N{1'b0}};
            end
            if (wr_en && (fill_ptr == 1'(b))) begin
                bank_state_n[b] = B_FILLING;
                mask_n[b]       = fill_mask_new;
            end
            if (becomes_full[b]) begin
                bank_state_n[b] = B_FULL;
            end
            if (start && (start_bank == 1'(b))) begin
                bank_state_n[b] = B_DRAINING;
            end
            if ((bank_state_n[b] != B_FULL) && (bank_state_n[b] != B_DRAINING)) begin
                collector_full_n = 1'b0;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge values regardless of statement order.
        if (!nRST) begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= B_EMPTY;
                mask[b]       <= {N{1'b0}};
            end
            fill_ptr       <= 1'b0;
            drain_ptr      <= 1'b0;
            d_state        <= D_IDLE;
            rcnt           <= {RW{1'b0}};
            wb_tile        <= {TILE_W{1'b0}};
            collector_full <= 1'b0;
            overflow_err   <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= bank_state_n[b];
                mask[b]       <= mask_n[b];
            end
            fill_ptr       <= fill_ptr_n;
            d_state        <= d_state_n;
            collector_full <= collector_full_n;
            overflow_err   <= overflow_err | (out_en && collector_full);
            if (hs) begin
                rcnt <= rcnt + RW'(1);
            end
            if (last_hs) begin
                drain_ptr <= ~drain_ptr;
                wb_tile   <= wb_tile + TILE_W'(1);
            end
        end
    end

`ifdef SYSARR_COLLECT_FLUSH_EN
    // Remember last cycle's drained so flush needs two consecutive cycles.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            drained_q <= 1'b0;
        end else begin
            drained_q <= drained;
        end
    end
`endif

    // Row storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the bank RAM is deliberately not reset; the row masks say
        // which entries are meaningful, so clearing the data buys nothing.
        if (wr_en) begin
            bank_data[fill_ptr][row_out] <= array_output;
        end
    end

    // Writeback read path; rows never written (flushed tile) read as zero.
    always_comb begin
        rd_row  = bank_data[drain_ptr][rcnt];
        wb_data = {DW{1'b0}};
        if (wb_valid && mask[drain_ptr][rcnt]) begin
            wb_data = rd_row;
        end
    end

    assign wb_row  = rcnt;
    assign wb_last = wb_valid && (rcnt == RW'(N - 1));

endmodule

// File: tb/tb_sysarr_output_collector.sv
// ---------------------------------------------------------------------------
// tb_sysarr_output_collector
//   Table-driven tiles plus hand-written sequences for backpressure, overflow,
//   reset mid-drain and the optional flush (SYSARR_COLLECT_FLUSH_EN).
//   Expected writeback beats go into a scoreboard queue as tiles are driven
//   and are popped by a monitor on each accepted beat.
// ---------------------------------------------------------------------------
module tb_sysarr_output_collector;

    localparam int N      = 4;
    localparam int WIDTH  = 16;
    localparam int TILE_W = 8;
    localparam int DW     = N * WIDTH;
    localparam int RW     = $clog2(N);

    logic              clk = 1'b0;
    logic              nRST;
    logic              out_en;
    logic [RW-1:0]     row_out;
    logic [DW-1:0]     array_output;
    logic              drained;
    logic              wb_valid;
    logic              wb_ready;
    logic [DW-1:0]     wb_data;
    logic [RW-1:0]     wb_row;
    logic [TILE_W-1:0] wb_tile;
    logic              wb_last;
    logic              collector_full;
    logic              overflow_err;

    sysarr_output_collector #(.N(N), .WIDTH(WIDTH), .TILE_W(TILE_W)) dut (
        .clk            (clk),
        .nRST           (nRST),
        .out_en         (out_en),
        .row_out        (row_out),
        .array_output   (array_output),
        .drained        (drained),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .wb_row         (wb_row),
        .wb_tile        (wb_tile),
        .wb_last        (wb_last),
        .collector_full (collector_full),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [RW-1:0]     row;
        logic [TILE_W-1:0] tile;
        logic              last;
    } beat_t;

    typedef struct {
        int                 wr_cnt;
        logic [5:0][RW-1:0] wr_row;
        logic [5:0][DW-1:0] wr_data;
        logic [N-1:0][DW-1:0] exp_data;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[4];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_tile = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [N-1:0][DW-1:0] rows);
        beat_t e;
        for (int r = 0; r < N; r++) begin
            e.data = rows[r];
            e.row  = RW'(r);
            e.tile = TILE_W'(exp_tile);
            e.last = (r == N - 1);
            sb.push_back(e);
        end
        exp_tile = (exp_tile + 1) % (1 << TILE_W);
    endtask

    // Drive one table vector; optionally expect it on writeback and check
    // that wb_valid rises exactly one cycle after the completing row.
    task automatic send_tile(input int v, input bit push, input bit chk_lat);
        for (int i = 0; i < vecs[v].wr_cnt; i++) begin
            if (chk_lat && (i == vecs[v].wr_cnt - 1)) begin
                check("valid_before_last_row", wb_valid, 0);
            end
            out_en       = 1'b1;
            row_out      = vecs[v].wr_row[i];
            array_output = vecs[v].wr_data[i];
            tick();
        end
        out_en = 1'b0;
        if (push) begin
            push_tile(vecs[v].exp_data);
        end
        if (chk_lat) begin
            @(negedge clk);
            check("valid_latency", wb_valid, 1);
        end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && sb.size() > 0; i++) begin
            tick();
        end
        check("drain_complete_remaining", sb.size(), 0);
        tick();
    endtask

    // Monitor: pop on each accepted beat; hold-stable check while stalled.
    logic          stall = 1'b0;
    logic [DW-1:0] held_data;
    logic [RW-1:0] held_row;

    always @(negedge clk) begin
        beat_t e;
        if (!nRST) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid_held", wb_valid, 1);
                check("stall_data_held", wb_data, held_data);
                check("stall_row_held", wb_row, held_row);
            end
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: row %0d data %h with empty scoreboard", wb_row, wb_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", wb_data, e.data);
                    check("beat_row", wb_row, e.row);
                    check("beat_tile", wb_tile, e.tile);
                    check("beat_last", wb_last, e.last);
                end
            end
            stall     = wb_valid && !wb_ready;
            held_data = wb_data;
            held_row  = wb_row;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: write sequence in, expected rows 0..N-1 out.
        vecs[0].wr_cnt   = 4;
        vecs[0].wr_row   = '{default: '0};
        vecs[0].wr_row[0] = 0; vecs[0].wr_row[1] = 1; vecs[0].wr_row[2] = 2; vecs[0].wr_row[3] = 3;
        vecs[0].exp_data[0] = 64'h0A0A_0B0B_0C0C_0D0D;
        vecs[0].exp_data[1] = 64'h1111_2222_3333_4444;
        vecs[0].exp_data[2] = 64'hDEAD_BEEF_0000_0001;
        vecs[0].exp_data[3] = 64'hFFFF_0000_FFFF_0000;
        vecs[0].wr_data  = '{default: '0};
        for (int i = 0; i < 4; i++) vecs[0].wr_data[i] = vecs[0].exp_data[i];

        vecs[1].wr_cnt   = 4;
        vecs[1].wr_row   = '{default: '0};
        vecs[1].wr_row[0] = 2; vecs[1].wr_row[1] = 0; vecs[1].wr_row[2] = 3; vecs[1].wr_row[3] = 1;
        vecs[1].wr_data  = '{default: '0};
        vecs[1].wr_data[0] = 64'h2222_2222_2222_2222;
        vecs[1].wr_data[1] = 64'h0000_0000_0000_0000;
        vecs[1].wr_data[2] = 64'h3333_3333_3333_3333;
        vecs[1].wr_data[3] = 64'h1111_1111_1111_1111;
        vecs[1].exp_data[0] = 64'h0000_0000_0000_0000;
        vecs[1].exp_data[1] = 64'h1111_1111_1111_1111;
        vecs[1].exp_data[2] = 64'h2222_2222_2222_2222;
        vecs[1].exp_data[3] = 64'h3333_3333_3333_3333;

        vecs[2].wr_cnt   = 4;
        vecs[2].wr_row   = '{default: '0};
        vecs[2].wr_row[0] = 3; vecs[2].wr_row[1] = 2; vecs[2].wr_row[2] = 1; vecs[2].wr_row[3] = 0;
        vecs[2].wr_data  = '{default: '0};
        vecs[2].wr_data[0] = 64'hC3C3_0000_0000_0003;
        vecs[2].wr_data[1] = 64'hC2C2_0000_0000_0002;
        vecs[2].wr_data[2] = 64'hC1C1_0000_0000_0001;
        vecs[2].wr_data[3] = 64'hC0C0_0000_0000_0000;
        vecs[2].exp_data[0] = 64'hC0C0_0000_0000_0000;
        vecs[2].exp_data[1] = 64'hC1C1_0000_0000_0001;
        vecs[2].exp_data[2] = 64'hC2C2_0000_0000_0002;
        vecs[2].exp_data[3] = 64'hC3C3_0000_0000_0003;

        // Duplicate row 1: the second write wins, mask unaffected.
        vecs[3].wr_cnt   = 5;
        vecs[3].wr_row   = '{default: '0};
        vecs[3].wr_row[0] = 1; vecs[3].wr_row[1] = 0; vecs[3].wr_row[2] = 1;
        vecs[3].wr_row[3] = 3; vecs[3].wr_row[4] = 2;
        vecs[3].wr_data  = '{default: '0};
        vecs[3].wr_data[0] = 64'hBAD0_BAD0_BAD0_BAD0;
        vecs[3].wr_data[1] = 64'h5A5A_0000_0000_0000;
        vecs[3].wr_data[2] = 64'h600D_600D_600D_600D;
        vecs[3].wr_data[3] = 64'h5A5A_3333_3333_3333;
        vecs[3].wr_data[4] = 64'h5A5A_2222_2222_2222;
        vecs[3].exp_data[0] = 64'h5A5A_0000_0000_0000;
        vecs[3].exp_data[1] = 64'h600D_600D_600D_600D;
        vecs[3].exp_data[2] = 64'h5A5A_2222_2222_2222;
        vecs[3].exp_data[3] = 64'h5A5A_3333_3333_3333;

        nRST         = 1'b0;
        out_en       = 1'b0;
        row_out      = '0;
        array_output = '0;
        drained      = 1'b0;
        wb_ready     = 1'b1;
        repeat (3) tick();

        // Reset state.
        @(negedge clk);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_last", wb_last, 0);
        check("rst_wb_tile", wb_tile, 0);
        check("rst_wb_row", wb_row, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_collector_full", collector_full, 0);
        check("rst_overflow_err", overflow_err, 0);
        nRST = 1'b1;
        tick();

        // Each table tile alone, wb_ready high.
        for (int v = 0; v < 4; v++) begin
            send_tile(v, 1'b1, 1'b1);
            wait_drain(40);
            check("idle_after_tile", wb_valid, 0);
        end

        // Backpressure: two tiles fill both banks, third is dropped.
        wb_ready = 1'b0;
        send_tile(0, 1'b1, 1'b0);
        check("full_after_one_tile", collector_full, 0);
        send_tile(1, 1'b1, 1'b0);
        check("full_after_two_tiles", collector_full, 1);
        check("no_overflow_yet", overflow_err, 0);
        send_tile(2, 1'b0, 1'b0);
        check("overflow_set", overflow_err, 1);
        wb_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            check("back_to_back_valid", wb_valid, 1);
        end
        @(negedge clk);
        check("dropped_tile_not_sent", wb_valid, 0);
        check("full_cleared", collector_full, 0);
        check("scoreboard_empty_b2b", sb.size(), 0);
        check("overflow_sticky", overflow_err, 1);
        tick();

        // Random wb_ready during two back-to-back tiles.
        fork
            begin
                send_tile(2, 1'b1, 1'b0);
                send_tile(3, 1'b1, 1'b0);
            end
            begin
                repeat (60) begin
                    wb_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                wb_ready = 1'b1;
            end
        join
        wait_drain(60);

        // Reset while beat 2 is presented.
        wb_ready = 1'b0;
        send_tile(0, 1'b1, 1'b0);
        wb_ready = 1'b1;
        tick();
        tick();
        wb_ready = 1'b0;
        @(negedge clk);
        check("beat2_before_reset", wb_row, 2);
        check("valid_before_reset", wb_valid, 1);
        nRST = 1'b0;
        tick();
        @(negedge clk);
        check("rst_mid_valid", wb_valid, 0);
        check("rst_mid_full", collector_full, 0);
        check("rst_mid_overflow", overflow_err, 0);
        check("rst_mid_tile", wb_tile, 0);
        nRST = 1'b1;
        sb.delete();
        exp_tile = 0;
        wb_ready = 1'b1;
        tick();
        send_tile(1, 1'b1, 1'b1);
        wait_drain(40);

        // Partial tile followed by two drained cycles.
        out_en = 1'b1; row_out = 0; array_output = 64'hF00D_0000_0000_0000; tick();
        out_en = 1'b1; row_out = 1; array_output = 64'hF00D_1111_1111_1111; tick();
        out_en = 1'b0;
`ifdef SYSARR_COLLECT_FLUSH_EN
        begin
            logic [N-1:0][DW-1:0] rows;
            rows[0] = 64'hF00D_0000_0000_0000;
            rows[1] = 64'hF00D_1111_1111_1111;
            rows[2] = '0;
            rows[3] = '0;
            push_tile(rows);
        end
        drained = 1'b1;
        tick();
        tick();
        drained = 1'b0;
        wait_drain(40);
`else
        drained = 1'b1;
        tick();
        tick();
        drained = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_flush_valid", wb_valid, 0);
        end
        begin
            logic [N-1:0][DW-1:0] rows;
            rows[0] = 64'hF00D_0000_0000_0000;
            rows[1] = 64'hF00D_1111_1111_1111;
            rows[2] = 64'hF00D_2222_2222_2222;
            rows[3] = 64'hF00D_3333_3333_3333;
            tick();
            out_en = 1'b1; row_out = 2; array_output = rows[2]; tick();
            out_en = 1'b1; row_out = 3; array_output = rows[3]; tick();
            out_en = 1'b0;
            push_tile(rows);
        end
        wait_drain(40);
`endif
        check("final_full", collector_full, 0);
        check("final_overflow", overflow_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
